tx_arbiter: RTL and testbench

Shares the single UART transmitter between up to NREQ byte sources, such as the screen refresh streamer, cursor updater, escape-sequence generator and echo path. It grants one requester at a time using round-robin, and it can lock the grant so that a multi-byte escape sequence is never interleaved with another source. It launches each byte with a one-cycle o_byte_v pulse and waits for i_tx_done before it accepts the next byte.

---
 rtl/tx_arbiter_pkg.sv | 13 +
 rtl/tx_arbiter_rr_pick.sv | 35 +++
 rtl/tx_arbiter.sv | 122 ++++++++++++
 tb/tb_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and watchdog limit.
package tx_arbiter_pkg;

   typedef enum logic [1:0] {
      TXA_IDLE = 2'd0,
      TXA_SEND = 2'd1,
      TXA_WAIT = 2'd2,
      TXA_HOLD = 2'd3
   } txa_state_t;

   localparam logic [15:0] TXA_WD_LIMIT = 16'hFFFF;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after rr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      int j;
      logic found;
      logic [IDX_W-1:0] cand;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(rr) + i;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         cand = IDX_W'(j);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
            grant = NREQ'(1) << cand;
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources, with grant lock.
// Optional watchdog on a lost tx_done is enabled by defining TXARB_WATCHDOG_EN.
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   i_req_v,
   input  logic [NREQ*8-1:0] i_req_byte,
   input  logic [NREQ-1:0]   i_req_lock,
   output logic [NREQ-1:0]   o_req_ack,
   output logic [NREQ-1:0]   o_grant,
   output logic [7:0]        o_byte,
   output logic              o_byte_v,
   input  logic              i_tx_active,
   input  logic              i_tx_done,
`ifdef TXARB_WATCHDOG_EN
   output logic              o_timeout,
`endif
   output logic              o_busy
);

   txa_state_t       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] rr;
   logic [IDX_W-1:0] next_rr;
   logic [NREQ-1:0]  pick_grant;
   logic [IDX_W-1:0] pick_idx;
`ifdef TXARB_WATCHDOG_EN
   logic [15:0]      wd_cnt;
`endif

   rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req   (i_req_v),
      .rr    (rr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   assign next_rr = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
   assign o_busy  = (state != TXA_IDLE);

   // A tx_done seen while o_byte_v is still high belongs to the previous byte and is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= TXA_IDLE;
         o_grant   <= '0;
         o_byte    <= '0;
         o_byte_v  <= 1'b0;
         o_req_ack <= '0;
         owner     <= '0;
         rr        <= '0;
`ifdef TXARB_WATCHDOG_EN
         wd_cnt    <= '0;
         o_timeout <= 1'b0;
`endif
      end else begin
         o_byte_v  <= 1'b0;
         o_req_ack <= '0;
`ifdef TXARB_WATCHDOG_EN
         o_timeout <= 1'b0;
`endif
         case (state)
            TXA_IDLE: begin
               if (|i_req_v && !i_tx_active) begin
                  o_grant <= pick_grant;
                  owner   <= pick_idx;
                  state   <= TXA_SEND;
               end
            end
            TXA_SEND: begin
               o_byte    <= i_req_byte[{owner, 3'b000} +: 8];
               o_byte_v  <= 1'b1;
               o_req_ack <= o_grant;
               state     <= TXA_WAIT;
`ifdef TXARB_WATCHDOG_EN
               wd_cnt    <= '0;
`endif
            end
            TXA_WAIT: begin
               if (i_tx_done && !o_byte_v) begin
                  if (i_req_lock[owner] && i_req_v[owner]) begin
                     state <= TXA_SEND;
                  end else if (i_req_lock[owner]) begin
                     state <= TXA_HOLD;
                  end else begin
                     o_grant <= '0;
                     rr      <= next_rr;
                     state   <= TXA_IDLE;
                  end
               end
`ifdef TXARB_WATCHDOG_EN
               else if (wd_cnt == TXA_WD_LIMIT - 16'd1) begin
                  o_grant   <= '0;
                  rr        <= next_rr;
                  o_timeout <= 1'b1;
                  state     <= TXA_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
`endif
            end
            TXA_HOLD: begin
               if (i_req_v[owner]) begin
                  state <= TXA_SEND;
               end else if (!i_req_lock[owner]) begin
                  o_grant <= '0;
                  rr      <= next_rr;
                  state   <= TXA_IDLE;
               end
            end
            default: begin
               state <= TXA_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: requester model, tx_done responder, ordered expected strobes.
// Define TXARB_WATCHDOG_EN to also exercise the watchdog timeout.
module tb_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  i_req_v;
   logic [31:0] i_req_byte;
   logic [3:0]  i_req_lock;
   logic [3:0]  o_req_ack;
   logic [3:0]  o_grant;
   logic [7:0]  o_byte;
   logic        o_byte_v;
   logic        i_tx_active;
   logic        i_tx_done;
   logic        o_busy;
`ifdef TXARB_WATCHDOG_EN
   logic        o_timeout;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [11:0] sb[$];
   logic [11:0] expv;
   logic [7:0]  req_mem[4][16];
   int          head[4] = '{default: 0};
   int          tail[4] = '{default: 0};
   logic [3:0]  req_lock_set = '0;
   int          done_timer = 0;
   bit          tx_auto = 1'b1;
   bit          early_done = 1'b0;
   int          last_strobe_cyc = 0;
   int          req_cyc = 0;

   tx_arbiter #(.NREQ(4), .IDX_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_v     (i_req_v),
      .i_req_byte  (i_req_byte),
      .i_req_lock  (i_req_lock),
      .o_req_ack   (o_req_ack),
      .o_grant     (o_grant),
      .o_byte      (o_byte),
      .o_byte_v    (o_byte_v),
      .i_tx_active (i_tx_active),
      .i_tx_done   (i_tx_done),
`ifdef TXARB_WATCHDOG_EN
      .o_timeout   (o_timeout),
`endif
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Queue a byte on requester k and record the strobe it should eventually produce.
   task automatic applyStimulus(input int k, input logic [7:0] b);
      req_mem[k][tail[k]] = b;
      tail[k]++;
      sb.push_back({4'(1 << k), b});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic waitQueue(input string tag, input int n, input bit wait_done);
      int t = 0;
      while ((sb.size() > n || (wait_done && done_timer != 0)) && t < 1000) begin
         tick();
         t++;
      end
      if (t >= 1000) checkOutput(tag, sb.size(), n);
   endtask

   task automatic waitIdle(input string tag);
      int t = 0;
      while ((sb.size() != 0 || done_timer != 0 || o_busy) && t < 1000) begin
         tick();
         t++;
      end
      if (t >= 1000) checkOutput(tag, sb.size() + done_timer + int'(o_busy), 0);
   endtask

   // Monitor, requester model and tx_done responder, all on the falling edge.
   initial begin
      i_req_v    = '0;
      i_req_byte = '0;
      i_req_lock = '0;
      i_tx_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (o_byte_v) begin
            last_strobe_cyc = cyc;
            if (sb.size() == 0) begin
               checkOutput("unexpected_strobe", {31'd0, o_byte_v}, 32'd0);
            end else begin
               expv = sb.pop_front();
               checkOutput("strobe_byte", o_byte, expv[7:0]);
               checkOutput("strobe_ack", o_req_ack, expv[11:8]);
               checkOutput("strobe_grant", o_grant, expv[11:8]);
            end
         end else if (o_req_ack != 4'd0) begin
            checkOutput("stray_ack", o_req_ack, 4'd0);
         end
         for (int k = 0; k < 4; k++) begin
            if (o_req_ack[k] && head[k] != tail[k]) head[k]++;
            i_req_v[k] = (head[k] != tail[k]);
            i_req_byte[8*k +: 8] = i_req_v[k] ? req_mem[k][head[k]] : 8'h00;
         end
         i_req_lock = req_lock_set;
         i_tx_done = 1'b0;
         if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) i_tx_done = 1'b1;
         end
         if (o_byte_v && tx_auto) begin
            done_timer = 10;
            if (early_done) i_tx_done = 1'b1;
         end
      end
   end

   initial begin
      rst = 1'b0;
      i_tx_active = 1'b0;
      repeat (2) tick();
      checkOutput("reset_grant", o_grant, 4'd0);
      checkOutput("reset_byte", o_byte, 8'd0);
      checkOutput("reset_byte_v", o_byte_v, 1'b0);
      checkOutput("reset_ack", o_req_ack, 4'd0);
      checkOutput("reset_busy", o_busy, 1'b0);
      rst = 1'b1;
      tick();

      $display("[TB] single request");
      applyStimulus(0, 8'h41);
      req_cyc = cyc;
      waitQueue("t1_strobe", 0, 1'b0);
      checkOutput("t1_latency", last_strobe_cyc - req_cyc, 2);
      checkOutput("t1_busy_wait", o_busy, 1'b1);
      waitIdle("t1_idle");
      checkOutput("t1_grant_released", o_grant, 4'd0);

      $display("[TB] tx_done during strobe cycle");
      early_done = 1'b1;
      applyStimulus(1, 8'h42);
      waitQueue("early_strobe", 0, 1'b0);
      early_done = 1'b0;
      repeat (3) tick();
      checkOutput("early_done_ignored", o_grant, 4'b0010);
      waitIdle("early_idle");

      $display("[TB] round robin");
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      applyStimulus(0, 8'hA0);
      applyStimulus(1, 8'hA1);
      applyStimulus(3, 8'hA3);
      waitIdle("t2_idle");
      applyStimulus(0, 8'hB0);
      applyStimulus(1, 8'hB1);
      waitIdle("t2_rr_wrap");

      $display("[TB] locked escape sequence");
      req_lock_set[2] = 1'b1;
      applyStimulus(2, 8'h1B);
      applyStimulus(2, 8'h5B);
      applyStimulus(2, 8'h48);
      waitQueue("t3_first", 2, 1'b0);
      applyStimulus(0, 8'h30);
      waitQueue("t3_seq", 1, 1'b1);
      repeat (3) tick();
      checkOutput("t3_hold_grant", o_grant, 4'b0100);
      checkOutput("t3_hold_busy", o_busy, 1'b1);
      checkOutput("t3_hold_pending", sb.size(), 1);
      req_lock_set[2] = 1'b0;
      waitIdle("t3_idle");

      $display("[TB] hold release");
      req_lock_set[1] = 1'b1;
      applyStimulus(1, 8'h55);
      waitQueue("t4_send", 0, 1'b1);
      repeat (2) tick();
      checkOutput("t4_hold_grant", o_grant, 4'b0010);
      req_lock_set[1] = 1'b0;
      tick();
      checkOutput("t4_released_grant", o_grant, 4'd0);
      checkOutput("t4_released_busy", o_busy, 1'b0);

      $display("[TB] tx_active defers launch");
      i_tx_active = 1'b1;
      applyStimulus(3, 8'h66);
      repeat (5) tick();
      checkOutput("t5_deferred_busy", o_busy, 1'b0);
      checkOutput("t5_deferred_pending", sb.size(), 1);
      i_tx_active = 1'b0;
      waitIdle("t5_idle");

      $display("[TB] reset during wait");
      applyStimulus(2, 8'h77);
      waitQueue("t6_strobe", 0, 1'b0);
      repeat (2) tick();
      #1 rst = 1'b0;
      #1;
      checkOutput("t6_rst_grant", o_grant, 4'd0);
      checkOutput("t6_rst_byte", o_byte, 8'd0);
      checkOutput("t6_rst_byte_v", o_byte_v, 1'b0);
      checkOutput("t6_rst_ack", o_req_ack, 4'd0);
      checkOutput("t6_rst_busy", o_busy, 1'b0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (12) tick();
      checkOutput("t6_after_done_busy", o_busy, 1'b0);
      applyStimulus(3, 8'h99);
      waitIdle("t6_fresh");

`ifdef TXARB_WATCHDOG_EN
      $display("[TB] watchdog");
      begin
         int t = 0;
         tx_auto = 1'b0;
         applyStimulus(0, 8'hC0);
         waitQueue("wd_strobe", 0, 1'b0);
         while (!o_timeout && t < 70000) begin
            tick();
            t++;
         end
         checkOutput("wd_timeout_seen", o_timeout, 1'b1);
         checkOutput("wd_delay", cyc - last_strobe_cyc, 65535);
         checkOutput("wd_grant", o_grant, 4'd0);
         tick();
         checkOutput("wd_pulse_width", o_timeout, 1'b0);
         tx_auto = 1'b1;
         applyStimulus(1, 8'hC1);
         waitIdle("wd_next");
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
